arb_hold: RTL and testbench

Registered grant-holding stage built around the strict-priority combinational arbiter. Turns a single-cycle priority decision into a locked, one-hot grant: once a requester wins, it keeps the grant across a burst of beats. The grant is released on request drop, on a `last` beat, or when a hold cap is reached. Sits between requester queues and a shared downstream resource (bus, memory port); the consumer paces beats with `ack`.

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_strict.sv | 9 +
 rtl/arb_hold.sv | 50 +++++
 tb/tb_arb_hold.sv | 133 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter types and helper functions
package arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned onehot2bin(input logic [255:0] v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 256; i++) r = v[i] ? r | i : r;
    return r;
  endfunction
endpackage

// File: rtl/arb_strict.sv
// arb_strict: combinational strict-priority arbiter, lowest index wins
module arb_strict #(
  parameter int WID = 16
) (
  input  logic [WID-1:0] rqsts,
  output logic [WID-1:0] grnts
);
  assign grnts = rqsts & (~rqsts + WID'(1));
endmodule

// File: rtl/arb_hold.sv
// arb_hold: registered one-hot grant held across a burst until drop, last beat or hold cap
module arb_hold
  import arb_pkg::*;
#(
  parameter int WID = 16,
  parameter int MAX_HOLD = 8,
  localparam int IW = idx_w(WID),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] rqsts,
  input  logic [WID-1:0] last,
  input  logic           ack,
  output logic [WID-1:0] grnts,
  output logic           gnt_vld,
  output logic [IW-1:0]  gnt_idx,
  output logic [HW-1:0]  hold_cnt
);
  state_t state, state_nx;
  logic [WID-1:0] grnts_nx, arb_in, win;
  logic [HW-1:0] cnt_nx;
  logic own_req, beat, rel;
  arb_strict #(.WID(WID)) u_strict (.rqsts(arb_in), .grnts(win));
  assign gnt_idx = IW'(onehot2bin(256'(grnts)));
  // release detection and next grant; the owner is masked out when re-arbitrating on release
  always_comb begin
    own_req = |(grnts & rqsts);
    beat = own_req & ack;
    rel = (state == BUSY) & (~own_req | (beat & ((|(grnts & last)) | (hold_cnt == HW'(MAX_HOLD - 1)))));
    arb_in = state == BUSY ? rqsts & ~grnts : rqsts;
    grnts_nx = (state == IDLE) | rel ? win : grnts;
    state_nx = |grnts_nx ? BUSY : IDLE;
    cnt_nx = (state == IDLE) | rel ? '0 : hold_cnt + HW'(beat);
  end
  // state, grant and beat counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grnts <= '0;
      gnt_vld <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= state_nx;
      grnts <= grnts_nx;
      gnt_vld <= |grnts_nx;
      hold_cnt <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_arb_hold.sv
// tb_arb_hold: directed stimulus with per-cycle model compare and literal checkpoints
module tb_arb_hold;
  localparam int WID = 16;
  localparam int MAX_HOLD = 8;
  logic clk = 0, rst = 1, ack = 0;
  logic [WID-1:0] rqsts = '0, last = '0, grnts;
  logic gnt_vld;
  logic [3:0] gnt_idx, hold_cnt;
  int cmp = 0, err = 0, own = -1, cnt = 0;
  bit chk_on = 0;
  arb_hold #(.WID(WID), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .rqsts(rqsts), .last(last), .ack(ack),
    .grnts(grnts), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .hold_cnt(hold_cnt)
  );
  always #5 clk = ~clk;
  function automatic int lowest(input logic [WID-1:0] v);
    for (int i = 0; i < WID; i++) if (v[i]) return i;
    return -1;
  endfunction
  // model: owner index and beat count, advanced from the inputs sampled at each edge
  always @(posedge clk) begin
    logic [WID-1:0] m;
    bit r, b;
    if (rst) begin
      own = -1;
      cnt = 0;
    end else if (own < 0) begin
      own = lowest(rqsts);
      cnt = 0;
    end else begin
      r = rqsts[own];
      b = r && ack;
      if (!r || (b && (last[own] || cnt + 1 == MAX_HOLD))) begin
        m = rqsts;
        m[own] = 1'b0;
        own = lowest(m);
        cnt = 0;
      end else if (b) cnt++;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // every-cycle comparison against the model
  always @(negedge clk) if (chk_on) begin
    chk("grnts", int'(grnts), own < 0 ? 0 : 1 << own);
    chk("gnt_vld", int'(gnt_vld), own >= 0 ? 1 : 0);
    chk("gnt_idx", int'(gnt_idx), own < 0 ? 0 : own);
    chk("hold_cnt", int'(hold_cnt), cnt);
  end
  task automatic step(input logic [WID-1:0] r, input logic [WID-1:0] l, input logic a);
    rqsts = r;
    last = l;
    ack = a;
    @(negedge clk);
  endtask
  task automatic lit(input string name, input int g, input int c);
    chk({name, "_grnts"}, int'(grnts), g);
    chk({name, "_cnt"}, int'(hold_cnt), c);
  endtask
  initial begin
    @(negedge clk);
    step(0, 0, 0);
    chk_on = 1;
    rst = 0;
    repeat (5) step(16'h0000, 0, 0);
    rst = 1;
    step(0, 0, 0);
    lit("reset", 0, 0);
    chk("reset_idx", int'(gnt_idx), 0);
    chk("reset_vld", int'(gnt_vld), 0);
    rst = 0;
    step(16'h0001, 0, 0);
    lit("first", 16'h0001, 0);
    chk("first_idx", int'(gnt_idx), 0);
    step(0, 0, 0);
    lit("first_drop", 0, 0);
    step(16'h0014, 0, 0);
    lit("prio", 16'h0004, 0);
    step(16'h0015, 0, 1);
    lit("lock1", 16'h0004, 1);
    step(16'h0015, 0, 1);
    lit("lock2", 16'h0004, 2);
    step(16'h0015, 16'h0004, 1);
    lit("last_hand", 16'h0001, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    lit("idle", 0, 0);
    step(16'h0220, 0, 0);
    lit("cap_own5", 16'h0020, 0);
    repeat (7) step(16'h0220, 0, 1);
    lit("cap_7", 16'h0020, 7);
    step(16'h0220, 0, 1);
    lit("cap_hand", 16'h0200, 0);
    chk("cap_idx", int'(gnt_idx), 9);
    repeat (3) step(16'h0220, 0, 0);
    lit("cap_keep9", 16'h0200, 0);
    step(16'h0020, 0, 0);
    lit("back5", 16'h0020, 0);
    step(0, 0, 0);
    step(16'h0008, 0, 0);
    step(16'h0008, 0, 1);
    lit("solo_beat", 16'h0008, 1);
    step(0, 0, 0);
    lit("solo_drop", 0, 0);
    step(16'h0008, 0, 0);
    repeat (8) step(16'h0008, 0, 1);
    lit("solo_cap", 0, 0);
    step(16'h0008, 0, 0);
    lit("solo_regrant", 16'h0008, 0);
    step(0, 0, 0);
    step(16'h0080, 0, 0);
    repeat (4) step(16'h0080, 0, 1);
    lit("mid4", 16'h0080, 4);
    rst = 1;
    step(16'h0080, 0, 1);
    lit("mid_rst", 0, 0);
    chk("mid_rst_vld", int'(gnt_vld), 0);
    rst = 0;
    step(0, 0, 1);
    lit("stray_ack", 0, 0);
    step(16'h0003, 16'h0003, 1);
    step(16'h0003, 16'h0003, 1);
    lit("last_hand2", 16'h0002, 0);
    step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
